// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage pipeline.
// Tracks destinations of in-flight instructions and selects the newest producer for each ID operand.
module fwd_hazard_unit #(
  parameter  int REGISTERWIDTH = 5,
  parameter  int DEPTH         = 3,
  localparam int SEL_W         = $clog2(DEPTH + 1),
  parameter  int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REGISTERWIDTH-1:0] id_rs1,
  input  logic [REGISTERWIDTH-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REGISTERWIDTH-1:0] id_rd,
  input  logic                     id_rd_we,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic                     hold,
  output logic [SEL_W-1:0]         fwd_sel1,
  output logic [SEL_W-1:0]         fwd_sel2,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_count
);

  logic [DEPTH:1]           r_valid;
  logic [DEPTH:1]           r_we;
  logic [DEPTH:1]           r_ld;
  logic [REGISTERWIDTH-1:0] r_rd [1:DEPTH];
  logic [CNT_W-1:0]         r_stall_count;

  logic [DEPTH:1]   w_hit1;
  logic [DEPTH:1]   w_hit2;
  logic [SEL_W-1:0] w_raw1;
  logic [SEL_W-1:0] w_raw2;
  logic             w_load_use;
  logic             w_accept;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_match
      assign w_hit1[gi] = r_valid[gi] && r_we[gi] && (r_rd[gi] == id_rs1) &&
                          (id_rs1 != '0) && id_use_rs1 && id_valid;
      assign w_hit2[gi] = r_valid[gi] && r_we[gi] && (r_rd[gi] == id_rs2) &&
                          (id_rs2 != '0) && id_use_rs2 && id_valid;
    end
  endgenerate

  // Scan from the oldest stage down so the nearest (newest) producer is the final assignment.
  always_comb begin
    w_raw1 = '0;
    w_raw2 = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (w_hit1[k]) w_raw1 = SEL_W'(k);
      if (w_hit2[k]) w_raw2 = SEL_W'(k);
    end
  end

  assign w_load_use = r_ld[1] && ((w_raw1 == SEL_W'(1)) || (w_raw2 == SEL_W'(1)));
  assign w_accept   = id_valid && !w_load_use && !flush;

  assign stall       = w_load_use;
  assign fwd_sel1    = w_load_use ? '0 : w_raw1;
  assign fwd_sel2    = w_load_use ? '0 : w_raw2;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid[1] <= 1'b0;
      r_we[1]    <= 1'b0;
      r_ld[1]    <= 1'b0;
      r_rd[1]    <= '0;
    end else if (!hold) begin
      r_valid[1] <= w_accept;
      r_we[1]    <= id_rd_we;
      r_ld[1]    <= id_is_load;
      r_rd[1]    <= id_rd;
    end
  end

  generate
    for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[gi] <= 1'b0;
          r_we[gi]    <= 1'b0;
          r_ld[gi]    <= 1'b0;
          r_rd[gi]    <= '0;
        end else if (!hold) begin
          r_valid[gi] <= r_valid[gi-1];
          r_we[gi]    <= r_we[gi-1];
          r_ld[gi]    <= r_ld[gi-1];
          r_rd[gi]    <= r_rd[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (!hold && w_load_use && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the MIPS-Lite 5-stage pipeline.
- Owns an internal destination-tracking pipeline, one entry per in-flight instruction ahead of ID. No shared global buffers.
- Computes, for each source operand in ID, which downstream stage supplies the newest value.
- Detects load-use hazards, stalls ID for exactly one cycle, and keeps a saturating stall counter for performance analysis.

Parameters:
- REGISTERWIDTH, 5, width of register addresses.
- DEPTH, 3, number of tracked stages ahead of ID (1=EX, 2=MEM, 3=WB); legal range 2..7.
- SEL_W, $clog2(DEPTH+1), width of forward-select outputs; derived, never overridden.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REGISTERWIDTH  source register 1 of ID instruction
- id_rs2  input  REGISTERWIDTH  source register 2
- id_use_rs1  input  1  instruction actually reads rs1
- id_use_rs2  input  1  instruction actually reads rs2
- id_rd  input  REGISTERWIDTH  destination register
- id_rd_we  input  1  instruction writes id_rd
- id_is_load  input  1  instruction is a load (opcode 0x0C class); data available only from stage 2
- flush  input  1  squash the ID instruction (branch taken); it must not enter stage 1
- hold  input  1  global pipeline freeze (memory wait)
- fwd_sel1  output  SEL_W  operand 1 source: 0=register file, k=stage k result
- fwd_sel2  output  SEL_W  operand 2 source, same encoding
- stall  output  1  load-use stall request to IF/ID
- stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Tracking entry k (1..DEPTH) holds {valid, rd, we, is_load}. Reset clears all valid bits and sets stall_count=0. With all entries invalid, fwd_sel1=fwd_sel2=0 and stall=0.
- Match for operand n at stage k: valid && we && rd==rs_n && rd!=0 && id_use_rsn && id_valid.
- fwd_seln = smallest k that matches; the newest producer wins. If no stage matches, fwd_seln=0. Register 0 never forwards.
- Load-use: stall=1 when either operand's smallest matching k is 1 and entry 1 has is_load=1. While stall=1, both fwd_sel outputs are forced to 0.
- fwd_sel and stall are combinational from the entries and ID inputs. There is no extra latency.
- Advance on each rising clk when hold=0:
  - Entry k+1 takes entry k; entry DEPTH is discarded.
  - Entry 1 takes the ID fields only when id_valid && !stall && !flush. Otherwise entry 1 becomes a bubble (valid=0).
- On the cycle after a load-use stall, the load sits in stage 2. The same ID instruction re-evaluates to fwd_sel=2 and stall=0. Each stall therefore lasts exactly one cycle.
- hold=1: all entries and stall_count are frozen. Outputs still track the current inputs.
- flush and stall together: a bubble is inserted and the flush takes priority (nothing enters).
- stall_count increments on a rising edge when stall && !hold. It saturates at all-ones with no wrap.
- Asserting rst_n low mid-operation clears entries immediately, without waiting for a clock edge.

Test Plan:
- ADD r3 followed by SUB using rs1=r3 -> fwd_sel1=1, fwd_sel2=0, stall=0.
- r3 written two instructions earlier with one unrelated instruction between -> fwd_sel2=2. Same test with DEPTH=4 and a gap of 3 -> fwd_sel=4 on the appropriate cycle.
- r5 written at both stage 1 and stage 3 -> fwd_sel1=1, the newest producer wins.
- LW r4 followed by ADD reading r4:
  - first cycle -> stall=1, sel=0, and entry 1 becomes a bubble;
  - next cycle -> stall=0, fwd_sel=2;
  - stall_count goes 0 to 1.
- Writer to r0 followed by a reader of r0 -> sel=0. Writer with we=0 -> sel=0. Reader with id_use_rs1=0 -> sel=0.
- Freeze, flush and reset, run as three separate checks:
  - hold=1 for 3 cycles mid-stream -> sel values unchanged and stall_count unchanged;
  - flush on a producer -> its consumer next cycle gets sel=0;
  - rst_n low mid-stream -> all outputs 0 asynchronously and stall_count=0.
- Force 65,536 or more stalls -> stall_count stays at 0xFFFF.
